// File: rtl/aes_bus_master.sv
// Bus master that runs one AES transaction on a simple register bus: configure,
// load key and block, poll for ready/valid, then collect the 16 result bytes.
module aes_bus_master #(
    parameter int POLL_LIMIT = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         cfg_encdec,
    input  logic         cfg_keylen,
    input  logic [255:0] key_in,
    input  logic [127:0] block_in,
    output logic         busy,
    output logic         done,
    output logic         timeout_err,
    output logic [127:0] result,
    output logic [3:0]   address,
    output logic [15:0]  data_in,
    input  logic [7:0]   data_out
);

    localparam int PW = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT + 1) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_CFG, S_KEY_CMD, S_KEY_DATA, S_INIT, S_POLL_RDY,
        S_BLK_CMD, S_BLK_DATA, S_NEXT, S_POLL_VLD, S_RESULT, S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     word_cnt_q, word_cnt_d;
    logic [4:0]     phase_cnt_q, phase_cnt_d;
    logic [PW-1:0]  poll_cnt_q, poll_cnt_d;
    logic           keylen_q, keylen_d;
    logic [255:0]   key_q, key_d;
    logic [127:0]   block_q, block_d;
    logic [127:0]   result_q, result_d;
    logic           timeout_err_q, timeout_err_d;
    logic [3:0]     address_q, address_d;
    logic [15:0]    data_in_q, data_in_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [7:0]     poll_match;
    state_t         poll_exit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            word_cnt_q    <= '0;
            phase_cnt_q   <= '0;
            poll_cnt_q    <= '0;
            keylen_q      <= 1'b0;
            key_q         <= '0;
            block_q       <= '0;
            result_q      <= '0;
            timeout_err_q <= 1'b0;
            address_q     <= '0;
            data_in_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            word_cnt_q    <= word_cnt_d;
            phase_cnt_q   <= phase_cnt_d;
            poll_cnt_q    <= poll_cnt_d;
            keylen_q      <= keylen_d;
            key_q         <= key_d;
            block_q       <= block_d;
            result_q      <= result_d;
            timeout_err_q <= timeout_err_d;
            address_q     <= address_d;
            data_in_q     <= data_in_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        word_cnt_d    = word_cnt_q;
        phase_cnt_d   = phase_cnt_q;
        poll_cnt_d    = poll_cnt_q;
        keylen_d      = keylen_q;
        key_d         = key_q;
        block_d       = block_q;
        result_d      = result_q;
        timeout_err_d = timeout_err_q;
        poll_match    = (state_q == S_POLL_RDY) ? 8'h01 : 8'h02;
        poll_exit     = (state_q == S_POLL_RDY) ? S_BLK_CMD : S_RESULT;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d       = S_CFG;
                    keylen_d      = cfg_keylen;
                    key_d         = key_in;
                    block_d       = block_in;
                    timeout_err_d = 1'b0;
                end
            end
            S_CFG:     state_d = S_KEY_CMD;
            S_KEY_CMD: begin
                state_d    = S_KEY_DATA;
                word_cnt_d = '0;
            end
            // Key and block are shifted out so the next word is always at the top.
            S_KEY_DATA: begin
                if (word_cnt_q == (keylen_q ? 4'd15 : 4'd7)) begin
                    state_d    = S_INIT;
                    word_cnt_d = '0;
                end else begin
                    word_cnt_d = word_cnt_q + 4'd1;
                    key_d      = key_q << 16;
                end
            end
            S_INIT, S_NEXT: begin
                state_d     = (state_q == S_INIT) ? S_POLL_RDY : S_POLL_VLD;
                phase_cnt_d = '0;
                poll_cnt_d  = '0;
            end
            // The first poll cycle only carries the previous command's response.
            S_POLL_RDY, S_POLL_VLD: begin
                if (phase_cnt_q == 5'd0) begin
                    phase_cnt_d = 5'd1;
                end else if (data_out == poll_match) begin
                    state_d     = poll_exit;
                    phase_cnt_d = '0;
                end else if (poll_cnt_q == PW'(POLL_LIMIT - 1)) begin
                    state_d       = S_DONE;
                    timeout_err_d = 1'b1;
                end else begin
                    poll_cnt_d = poll_cnt_q + 1'b1;
                end
            end
            S_BLK_CMD: begin
                state_d    = S_BLK_DATA;
                word_cnt_d = '0;
            end
            S_BLK_DATA: begin
                if (word_cnt_q == 4'd7) begin
                    state_d    = S_NEXT;
                    word_cnt_d = '0;
                end else begin
                    word_cnt_d = word_cnt_q + 4'd1;
                    block_d    = block_q << 16;
                end
            end
            S_RESULT: begin
                for (int b = 0; b < 16; b++) begin
                    if (phase_cnt_q == 5'(b + 1)) begin
                        result_d[127 - 8*b -: 8] = data_out;
                    end
                end
                if (phase_cnt_q == 5'd16) begin
                    state_d = S_DONE;
                end else begin
                    phase_cnt_d = phase_cnt_q + 5'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state so they register in step with it.
    always_comb begin
        address_d = 4'd0;
        data_in_d = 16'd0;
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        case (state_d)
            S_CFG: begin
                address_d = 4'd1;
                data_in_d = {14'b0, cfg_keylen, cfg_encdec};
            end
            S_KEY_CMD:  address_d = 4'd2;
            S_KEY_DATA: data_in_d = key_d[255:240];
            S_INIT: begin
                address_d = 4'd6;
                data_in_d = 16'h0001;
            end
            S_POLL_RDY, S_POLL_VLD: address_d = 4'd5;
            S_BLK_CMD:  address_d = 4'd3;
            S_BLK_DATA: data_in_d = block_d[127:112];
            S_NEXT: begin
                address_d = 4'd6;
                data_in_d = 16'h0002;
            end
            S_RESULT: address_d = 4'd7;
            default: begin
                address_d = 4'd0;
                data_in_d = 16'd0;
            end
        endcase
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = timeout_err_q;
    assign result      = result_q;
    assign address     = address_q;
    assign data_in     = data_in_q;

endmodule

// File: tb/tb_aes_bus_master.sv
// Bench for aes_bus_master: a bus responder plus a transaction-level model that
// predicts the full per-cycle bus trace, latency, result and timeout flag.
module tb_aes_bus_master;

    localparam int PL = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         cfg_encdec;
    logic         cfg_keylen;
    logic [255:0] key_in;
    logic [127:0] block_in;
    logic         busy;
    logic         done;
    logic         timeout_err;
    logic [127:0] result;
    logic [3:0]   address;
    logic [15:0]  data_in;
    logic [7:0]   data_out = 8'h00;

    aes_bus_master #(.POLL_LIMIT(PL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_encdec(cfg_encdec),
        .cfg_keylen(cfg_keylen), .key_in(key_in), .block_in(block_in),
        .busy(busy), .done(done), .timeout_err(timeout_err), .result(result),
        .address(address), .data_in(data_in), .data_out(data_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         keylen;
        logic         enc;
        logic [255:0] key;
        logic [127:0] blk;
        int           rdy_m;
        int           vld_m;
        logic [127:0] res;
        int           exp_lat;
    } txn_t;

    typedef struct {
        logic [3:0]  a;
        logic [15:0] d;
    } bus_t;

    int           errors = 0;
    int           checks = 0;
    bus_t         exp_q[$];
    logic         exp_to;
    logic [127:0] model_result = '0;

    // Responder configuration for the current transaction
    int           rdy_m = 1;
    int           vld_m = 1;
    logic [127:0] res_word = '0;
    int           cur_m = 1;
    logic [7:0]   cur_code = 8'h01;
    int           poll_p = 0;
    int           res_p = 0;
    logic [7:0]   resp_r;

    // Registered responder; on a command cycle it answers with that phase's match
    // code, which the master must discard as latency junk.
    always @(posedge clk) begin
        resp_r = 8'($urandom);
        if (address == 4'd5) begin
            if (poll_p >= cur_m - 1) data_out <= cur_code;
            else data_out <= (resp_r == cur_code) ? 8'h00 : resp_r;
            poll_p++;
        end else begin
            poll_p = 0;
        end
        if (address == 4'd7) begin
            data_out <= (res_p < 16) ? 8'(res_word >> (120 - 8*res_p)) : 8'hEE;
            res_p++;
        end else begin
            res_p = 0;
        end
        if (address == 4'd6) begin
            cur_code = data_in[7:0];
            cur_m    = (data_in == 16'h0001) ? rdy_m : vld_m;
            data_out <= data_in[7:0];
        end else if (address != 4'd5 && address != 4'd7) begin
            data_out <= resp_r;
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void push(input logic [3:0] a, input logic [15:0] d);
        bus_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endfunction

    // Whole-transaction bus trace built from the command sequence rules
    function automatic void buildTrace(input txn_t t);
        exp_q.delete();
        exp_to = 1'b0;
        push(4'd1, {14'b0, t.keylen, t.enc});
        push(4'd2, 16'd0);
        for (int i = 0; i < (t.keylen ? 16 : 8); i++) push(4'd0, 16'(t.key >> (240 - 16*i)));
        push(4'd6, 16'h0001);
        if (t.rdy_m > PL) begin
            repeat (1 + PL) push(4'd5, 16'd0);
            push(4'd0, 16'd0);
            exp_to = 1'b1;
            return;
        end
        repeat (1 + t.rdy_m) push(4'd5, 16'd0);
        push(4'd3, 16'd0);
        for (int i = 0; i < 8; i++) push(4'd0, 16'(t.blk >> (112 - 16*i)));
        push(4'd6, 16'h0002);
        if (t.vld_m > PL) begin
            repeat (1 + PL) push(4'd5, 16'd0);
            push(4'd0, 16'd0);
            exp_to = 1'b1;
            return;
        end
        repeat (1 + t.vld_m) push(4'd5, 16'd0);
        repeat (17) push(4'd7, 16'd0);
        push(4'd0, 16'd0);
    endfunction

    // Runs one transaction; glitch_at pulses start at that trace index, reset_at
    // asserts rst_n there and abandons the transaction.
    task automatic applyStimulus(input txn_t t, input int glitch_at, input int reset_at);
        int n;
        int done_at;
        logic [127:0] exp_res;
        buildTrace(t);
        n        = exp_q.size();
        rdy_m    = t.rdy_m;
        vld_m    = t.vld_m;
        res_word = t.res;
        done_at  = 0;
        start      = 1'b1;
        cfg_keylen = t.keylen;
        cfg_encdec = t.enc;
        key_in     = t.key;
        block_in   = t.blk;
        @(posedge clk);
        #1;
        start      = 1'b0;
        cfg_keylen = 1'($urandom);
        cfg_encdec = 1'($urandom);
        key_in     = {8{$urandom}};
        block_in   = {4{$urandom}};
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
                start = 1'b0;
            end
            if (i == 0) checkOutput("busy_cfg", {busy, timeout_err}, 2'b10);
            checkOutput($sformatf("trace[%0d]", i), {done, address, data_in},
                        {(i == n - 1), exp_q[i].a, exp_q[i].d});
            if (done === 1'b1 && done_at == 0) done_at = i + 1;
            if (i == reset_at) begin
                rst_n = 1'b0;
                #1;
                checkOutput("reset_abort", {busy, done, timeout_err, address, data_in, result},
                            '0);
                model_result = '0;
                #3;
                rst_n = 1'b1;
                return;
            end
            if (i == glitch_at) begin
                start      = 1'b1;
                cfg_keylen = ~t.keylen;
                key_in     = {8{$urandom}};
            end
        end
        exp_res = exp_to ? model_result : t.res;
        if (!exp_to) model_result = t.res;
        checkOutput("latency", done_at, (t.exp_lat > 0) ? t.exp_lat : n);
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("idle_after", {busy, done, address, data_in}, '0);
        checkOutput("result", result, exp_res);
        checkOutput("timeout_err", timeout_err, exp_to);
    endtask

    txn_t vecs[5];
    txn_t rt;

    initial begin
        vecs[0] = '{1'b1, 1'b1,
                    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                    128'h00112233445566778899aabbccddeeff, 1, 1,
                    128'h8ea2b7ca516745bfeafc49904b496089, 51};
        vecs[1] = '{1'b0, 1'b1,
                    {128'h000102030405060708090a0b0c0d0e0f, 128'hdeadbeefcafef00d0123456789abcdef},
                    128'h00112233445566778899aabbccddeeff, 1, 1,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 43};
        vecs[2] = '{1'b0, 1'b1,
                    {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                    128'h00112233445566778899aabbccddeeff, 99, 1,
                    128'h11111111111111111111111111111111, 17};
        vecs[3] = '{1'b0, 1'b0,
                    {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 3, 4,
                    128'h00112233445566778899aabbccddeeff, 48};
        vecs[4] = '{1'b1, 1'b0,
                    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                    128'h8ea2b7ca516745bfeafc49904b496089, 2, 50,
                    128'h22222222222222222222222222222222, 38};

        rst_n      = 1'b0;
        start      = 1'b0;
        cfg_encdec = 1'b0;
        cfg_keylen = 1'b0;
        key_in     = '0;
        block_in   = '0;
        #2;
        checkOutput("reset_state", {busy, done, timeout_err, address, data_in, result}, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("idle_no_start", {busy, done, address, data_in}, '0);

        $display("[TB] directed vectors");
        for (int v = 0; v < 5; v++) applyStimulus(vecs[v], -1, -1);

        $display("[TB] start pulses mid-KEY_DATA and in the done cycle");
        applyStimulus(vecs[1], 4, -1);
        applyStimulus(vecs[0], 50, -1);

        $display("[TB] reset during BLK_DATA, then a clean transaction");
        applyStimulus(vecs[1], -1, 16);
        @(posedge clk);
        #1;
        checkOutput("post_reset_idle", {busy, done, address, data_in, result}, '0);
        applyStimulus(vecs[1], -1, -1);

        $display("[TB] randomized transactions");
        for (int k = 0; k < 20; k++) begin
            rt.keylen  = 1'($urandom);
            rt.enc     = 1'($urandom);
            rt.key     = {8{$urandom}};
            rt.blk     = {4{$urandom}};
            rt.rdy_m   = $urandom_range(1, 6);
            rt.vld_m   = $urandom_range(1, 6);
            rt.res     = {4{$urandom}};
            rt.exp_lat = 0;
            applyStimulus(rt, -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
